// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/exec side-band bundle between the pipeline and hazard_ctrl.
//   master : pipeline side, drives the ID instruction description and the exec redirect,
//            consumes stall/flush/issue, forwarding selects and event counters.
//   slave  : hazard_ctrl side.
// Signals:
//   dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
//   dec_rd_write_enable, dec_rd_addr, dec_is_load  - ID instruction description
//   pc_src                                         - exec redirect
//   stall_if, stall_id, flush_id, issue            - combinational sequencing controls
//   fwd_a_sel, fwd_b_sel                           - registered operand bypass selects
//   stall_count, flush_count                       - free-running event counters
interface hazard_ctrl_if;
   logic        dec_valid;
   logic [4:0]  dec_rs1_addr;
   logic [4:0]  dec_rs2_addr;
   logic        dec_uses_rs1;
   logic        dec_uses_rs2;
   logic        dec_rd_write_enable;
   logic [4:0]  dec_rd_addr;
   logic        dec_is_load;
   logic        pc_src;
   logic        stall_if;
   logic        stall_id;
   logic        flush_id;
   logic        issue;
   logic [1:0]  fwd_a_sel;
   logic [1:0]  fwd_b_sel;
   logic [31:0] stall_count;
   logic [31:0] flush_count;

   modport master (
      output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
             dec_rd_write_enable, dec_rd_addr, dec_is_load, pc_src,
      input  stall_if, stall_id, flush_id, issue, fwd_a_sel, fwd_b_sel,
             stall_count, flush_count
   );

   modport slave (
      input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
             dec_rd_write_enable, dec_rd_addr, dec_is_load, pc_src,
      output stall_if, stall_id, flush_id, issue, fwd_a_sel, fwd_b_sel,
             stall_count, flush_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the five-stage pipeline.
// Tracks the destinations of the EX and MEM instructions, raises a one-cycle load-use stall,
// produces registered operand-forwarding selects and squashes decode for FLUSH_CYCLES cycles
// on every exec redirect. Also counts stall cycles and redirects.
// Ports:
//   clk   - pipeline clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - hazard_ctrl_if.slave (decode description in, sequencing/forwarding/counters out)
// Parameter:
//   FLUSH_CYCLES - decode squash length per redirect including the pc_src cycle, 1..15
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave bus
);

   typedef enum logic {StRun, StFlush} state_e;

   typedef struct packed {
      logic       v;
      logic       wr;
      logic [4:0] rd;
      logic       ld;
   } sb_entry_t;

   localparam logic       MultiFlush = (FLUSH_CYCLES > 1);
   localparam logic [3:0] FlushInit  = 4'(FLUSH_CYCLES - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;
   sb_entry_t   ex_q, mem_q, ex_d;
   logic [1:0]  fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
   logic [31:0] stall_count_q, flush_count_q;
   logic        hz_load, stall, flush, issue;

   function automatic logic match(input sb_entry_t e, input logic [4:0] rs);
      return e.v && e.wr && (e.rd == rs);
   endfunction

   // Youngest producer wins; a load still in EX cannot bypass (that case stalls instead).
   function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                          input sb_entry_t ex, input sb_entry_t mem);
      if (used && match(ex, rs) && !ex.ld) return 2'd1;
      else if (used && match(mem, rs)) return 2'd2;
      else return 2'd0;
   endfunction

   always_comb begin
      hz_load = (state_q == StRun) && bus.dec_valid && ex_q.ld &&
                ((bus.dec_uses_rs1 && match(ex_q, bus.dec_rs1_addr)) ||
                 (bus.dec_uses_rs2 && match(ex_q, bus.dec_rs2_addr)));
      // A redirect squashes the consumer anyway, so it overrides the load-use stall.
      stall   = hz_load && !bus.pc_src;
      flush   = bus.pc_src || (state_q == StFlush);
      issue   = bus.dec_valid && !hz_load && !flush;

      ex_d    = '0;
      fwd_a_d = 2'd0;
      fwd_b_d = 2'd0;
      if (issue) begin
         ex_d.v  = 1'b1;
         // x0 is never a real destination, so it must never match a consumer.
         ex_d.wr = bus.dec_rd_write_enable && (bus.dec_rd_addr != 5'd0);
         ex_d.rd = bus.dec_rd_addr;
         ex_d.ld = bus.dec_is_load;
         fwd_a_d = fwd_sel(bus.dec_uses_rs1, bus.dec_rs1_addr, ex_q, mem_q);
         fwd_b_d = fwd_sel(bus.dec_uses_rs2, bus.dec_rs2_addr, ex_q, mem_q);
      end
   end

   // Redirect sequencer. cnt_q holds the remaining squash cycles after the pc_src cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         cnt_q   <= 4'd0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (bus.pc_src && MultiFlush) begin
                  state_q <= StFlush;
                  cnt_q   <= FlushInit;
               end
            end
            StFlush: begin
               // pc_src is ignored here: EX only holds bubbles during the squash.
               if (cnt_q == 4'd1) begin
                  state_q <= StRun;
                  cnt_q   <= 4'd0;
               end else begin
                  cnt_q   <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= StRun;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q          <= '0;
         mem_q         <= '0;
         fwd_a_q       <= 2'd0;
         fwd_b_q       <= 2'd0;
         stall_count_q <= 32'd0;
         flush_count_q <= 32'd0;
      end else begin
         mem_q   <= ex_q;
         ex_q    <= ex_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         if (stall) stall_count_q <= stall_count_q + 32'd1;
         if (bus.pc_src && (state_q == StRun)) flush_count_q <= flush_count_q + 32'd1;
      end
   end

   assign bus.stall_if    = stall;
   assign bus.stall_id    = stall;
   assign bus.flush_id    = flush;
   assign bus.issue       = issue;
   assign bus.fwd_a_sel   = fwd_a_q;
   assign bus.fwd_b_sel   = fwd_b_q;
   assign bus.stall_count = stall_count_q;
   assign bus.flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl.
// Each scenario task walks a table of decode cycles, checks the combinational controls inline
// and pushes the expected forwarding selects, which are popped and compared one cycle later.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hazard_ctrl_if bus ();
   hazard_ctrl_if bus1 ();

   hazard_ctrl #(.FLUSH_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   hazard_ctrl #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       we;
      logic [4:0] rd;
      logic       ld;
      logic       pc;
      logic [3:0] ctl;  // expected {stall_if, stall_id, flush_id, issue}
      logic [1:0] fa;
      logic [1:0] fb;
   } step_t;

   typedef struct {
      int         due;
      logic [1:0] a;
      logic [1:0] b;
      string      nm;
   } fwd_exp_t;

   fwd_exp_t    sb_q[$];
   int          cyc_n = 0;
   int          n_checks = 0;
   int          n_fails = 0;
   int          exp_stalls = 0;
   int          exp_flushes = 0;

   function automatic step_t st(int v, int rs1, int rs2, int u1, int u2, int we, int rd,
                                int ld, int pc, int ctl, int fa, int fb);
      step_t s;
      s.v = 1'(v); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.u1 = 1'(u1); s.u2 = 1'(u2);
      s.we = 1'(we); s.rd = 5'(rd); s.ld = 1'(ld); s.pc = 1'(pc);
      s.ctl = 4'(ctl); s.fa = 2'(fa); s.fb = 2'(fb);
      return s;
   endfunction

   function automatic step_t idle_s();
      return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0);
   endfunction

   task automatic drive(input step_t s);
      bus.dec_valid           = s.v;
      bus.dec_rs1_addr        = s.rs1;
      bus.dec_rs2_addr        = s.rs2;
      bus.dec_uses_rs1        = s.u1;
      bus.dec_uses_rs2        = s.u2;
      bus.dec_rd_write_enable = s.we;
      bus.dec_rd_addr         = s.rd;
      bus.dec_is_load         = s.ld;
      bus.pc_src              = s.pc;
   endtask

   task automatic push_fwd(input logic [1:0] a, input logic [1:0] b, input string nm);
      fwd_exp_t e;
      e.due = cyc_n + 1;
      e.a   = a;
      e.b   = b;
      e.nm  = nm;
      sb_q.push_back(e);
   endtask

   // Advance one clock and retire every forwarding expectation due in the new cycle.
   task automatic tick();
      fwd_exp_t e;
      @(posedge clk);
      #1;
      cyc_n++;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc_n) begin
         e = sb_q.pop_front();
         n_checks++;
         if (e.due != cyc_n || bus.fwd_a_sel !== e.a || bus.fwd_b_sel !== e.b) begin
            n_fails++;
            $display("FAIL %s fwd_a/b_sel: got %0d,%0d want %0d,%0d (due %0d now %0d)",
                     e.nm, bus.fwd_a_sel, bus.fwd_b_sel, e.a, e.b, e.due, cyc_n);
         end
      end
   endtask

   task automatic test_reset();
      step_t s[2];
      rst_n = 1'b0;
      drive(idle_s());
      bus1.dec_valid = 1'b0; bus1.dec_rs1_addr = 5'd0; bus1.dec_rs2_addr = 5'd0;
      bus1.dec_uses_rs1 = 1'b0; bus1.dec_uses_rs2 = 1'b0; bus1.dec_rd_write_enable = 1'b0;
      bus1.dec_rd_addr = 5'd0; bus1.dec_is_load = 1'b0; bus1.pc_src = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue} !== 4'b0000) begin
         n_fails++;
         $display("FAIL reset ctl: got %b want 0000",
                  {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue});
      end
      n_checks++;
      if ({bus.fwd_a_sel, bus.fwd_b_sel} !== 4'b0000) begin
         n_fails++;
         $display("FAIL reset fwd: got %b want 0000", {bus.fwd_a_sel, bus.fwd_b_sel});
      end
      n_checks++;
      if ({bus.stall_count, bus.flush_count, bus1.flush_count} !== 96'd0) begin
         n_fails++;
         $display("FAIL reset counters: got %h %h %h want 0", bus.stall_count,
                  bus.flush_count, bus1.flush_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      s = '{st(1, 1, 2, 0, 0, 1, 4, 0, 0, 'b0001, 0, 0), idle_s()};
      foreach (s[i]) begin
         drive(s[i]);
         #2;
         n_checks++;
         if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue} !== s[i].ctl) begin
            n_fails++;
            $display("FAIL reset_release step %0d ctl: got %b want %b", i,
                     {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue}, s[i].ctl);
         end
         push_fwd(s[i].fa, s[i].fb, $sformatf("reset_release step %0d", i));
         tick();
      end
   endtask

   task automatic test_alu_back_to_back();
      step_t s[9];
      s = '{idle_s(), idle_s(),
            st(1, 1, 2, 1, 1, 1, 5, 0, 0, 'b0001, 0, 0),   // add x5,x1,x2
            st(1, 5, 7, 1, 1, 1, 6, 0, 0, 'b0001, 1, 0),   // sub x6,x5,x7 -> EX bypass
            idle_s(), idle_s(),
            st(1, 1, 2, 1, 1, 1, 5, 0, 0, 'b0001, 0, 0),   // add x5
            idle_s(),                                      // bubble
            st(1, 5, 7, 1, 1, 1, 6, 0, 0, 'b0001, 2, 0)};  // sub -> MEM bypass
      foreach (s[i]) begin
         drive(s[i]);
         #2;
         n_checks++;
         if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue} !== s[i].ctl) begin
            n_fails++;
            $display("FAIL alu_b2b step %0d ctl: got %b want %b", i,
                     {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue}, s[i].ctl);
         end
         push_fwd(s[i].fa, s[i].fb, $sformatf("alu_b2b step %0d", i));
         tick();
      end
   endtask

   task automatic test_load_use();
      step_t s[5];
      s = '{idle_s(), idle_s(),
            st(1, 2, 0, 1, 0, 1, 8, 1, 0, 'b0001, 0, 0),   // lw x8
            st(1, 8, 8, 1, 1, 1, 9, 0, 0, 'b1100, 0, 0),   // add x9,x8,x8 stalls
            st(1, 8, 8, 1, 1, 1, 9, 0, 0, 'b0001, 2, 2)};  // issues, load now in MEM
      foreach (s[i]) begin
         drive(s[i]);
         #2;
         n_checks++;
         if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue} !== s[i].ctl) begin
            n_fails++;
            $display("FAIL load_use step %0d ctl: got %b want %b", i,
                     {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue}, s[i].ctl);
         end
         push_fwd(s[i].fa, s[i].fb, $sformatf("load_use step %0d", i));
         tick();
      end
      exp_stalls++;
      n_checks++;
      if (bus.stall_count !== 32'(exp_stalls)) begin
         n_fails++;
         $display("FAIL load_use stall_count: got %0d want %0d", bus.stall_count, exp_stalls);
      end
   endtask

   task automatic test_x0_priority();
      step_t s[9];
      s = '{idle_s(), idle_s(),
            st(1, 0, 0, 0, 0, 1, 0, 1, 0, 'b0001, 0, 0),    // load into x0
            st(1, 0, 0, 1, 1, 1, 11, 0, 0, 'b0001, 0, 0),   // reads x0: no stall, no bypass
            idle_s(), idle_s(),
            st(1, 0, 0, 0, 0, 1, 3, 0, 0, 'b0001, 0, 0),    // x3 producer (ends in MEM)
            st(1, 0, 0, 0, 0, 1, 3, 0, 0, 'b0001, 0, 0),    // x3 producer (ends in EX)
            st(1, 3, 3, 1, 1, 1, 10, 0, 0, 'b0001, 1, 1)};  // EX wins over MEM
      foreach (s[i]) begin
         drive(s[i]);
         #2;
         n_checks++;
         if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue} !== s[i].ctl) begin
            n_fails++;
            $display("FAIL x0_prio step %0d ctl: got %b want %b", i,
                     {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue}, s[i].ctl);
         end
         push_fwd(s[i].fa, s[i].fb, $sformatf("x0_prio step %0d", i));
         tick();
      end
      // EX now holds x10, MEM holds x3; rs1 is unused so it must not bypass.
      drive(st(1, 3, 3, 0, 1, 0, 0, 0, 0, 'b0001, 0, 2));
      #2;
      push_fwd(2'd0, 2'd2, "x0_prio unused_rs1");
      tick();
   endtask

   task automatic test_redirect();
      step_t s[5];
      s = '{idle_s(), idle_s(),
            st(1, 1, 2, 0, 0, 0, 0, 0, 1, 'b0010, 0, 0),   // pc_src in RUN
            st(1, 1, 2, 0, 0, 0, 0, 0, 1, 'b0010, 0, 0),   // pc_src ignored in FLUSH
            st(1, 1, 2, 0, 0, 0, 0, 0, 0, 'b0001, 0, 0)};
      foreach (s[i]) begin
         drive(s[i]);
         #2;
         n_checks++;
         if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue} !== s[i].ctl) begin
            n_fails++;
            $display("FAIL redirect step %0d ctl: got %b want %b", i,
                     {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue}, s[i].ctl);
         end
         push_fwd(s[i].fa, s[i].fb, $sformatf("redirect step %0d", i));
         tick();
      end
      exp_flushes++;
      n_checks++;
      if (bus.flush_count !== 32'(exp_flushes)) begin
         n_fails++;
         $display("FAIL redirect flush_count: got %0d want %0d", bus.flush_count, exp_flushes);
      end
      // Single-cycle squash instance.
      drive(idle_s());
      bus1.dec_valid = 1'b1;
      bus1.pc_src    = 1'b1;
      #2;
      n_checks++;
      if ({bus1.flush_id, bus1.issue} !== 2'b10) begin
         n_fails++;
         $display("FAIL redirect1 pc cycle {flush_id,issue}: got %b want 10",
                  {bus1.flush_id, bus1.issue});
      end
      tick();
      bus1.pc_src = 1'b0;
      #2;
      n_checks++;
      if ({bus1.flush_id, bus1.issue} !== 2'b01) begin
         n_fails++;
         $display("FAIL redirect1 next cycle {flush_id,issue}: got %b want 01",
                  {bus1.flush_id, bus1.issue});
      end
      n_checks++;
      if (bus1.flush_count !== 32'd1) begin
         n_fails++;
         $display("FAIL redirect1 flush_count: got %0d want 1", bus1.flush_count);
      end
      tick();
      bus1.dec_valid = 1'b0;
   endtask

   task automatic test_redirect_vs_load_use();
      step_t s[6];
      s = '{idle_s(), idle_s(),
            st(1, 2, 0, 1, 0, 1, 8, 1, 0, 'b0001, 0, 0),   // lw x8
            st(1, 8, 8, 1, 1, 1, 9, 0, 1, 'b0010, 0, 0),   // load-use + redirect: flush wins
            st(1, 8, 8, 1, 1, 1, 9, 0, 0, 'b0010, 0, 0),   // second squash cycle
            st(1, 8, 8, 1, 1, 1, 9, 0, 0, 'b0001, 0, 0)};  // load already retired
      foreach (s[i]) begin
         drive(s[i]);
         #2;
         n_checks++;
         if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue} !== s[i].ctl) begin
            n_fails++;
            $display("FAIL redir_vs_lu step %0d ctl: got %b want %b", i,
                     {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue}, s[i].ctl);
         end
         push_fwd(s[i].fa, s[i].fb, $sformatf("redir_vs_lu step %0d", i));
         tick();
      end
      exp_flushes++;
      n_checks++;
      if ({bus.stall_count, bus.flush_count} !== {32'(exp_stalls), 32'(exp_flushes)}) begin
         n_fails++;
         $display("FAIL redir_vs_lu counters: got stall %0d flush %0d want stall %0d flush %0d",
                  bus.stall_count, bus.flush_count, exp_stalls, exp_flushes);
      end
   endtask

   task automatic test_counter_wrap();
      step_t s[3];
      drive(idle_s());
      force dut.stall_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_count_q;
      #1;
      n_checks++;
      if (bus.stall_count !== 32'hFFFF_FFFF) begin
         n_fails++;
         $display("FAIL wrap preload stall_count: got %h want ffffffff", bus.stall_count);
      end
      s = '{st(1, 2, 0, 1, 0, 1, 8, 1, 0, 'b0001, 0, 0),
            st(1, 8, 8, 1, 1, 1, 9, 0, 0, 'b1100, 0, 0),
            st(1, 8, 8, 1, 1, 1, 9, 0, 0, 'b0001, 2, 2)};
      foreach (s[i]) begin
         tick();
         drive(s[i]);
         #2;
         n_checks++;
         if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue} !== s[i].ctl) begin
            n_fails++;
            $display("FAIL wrap step %0d ctl: got %b want %b", i,
                     {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue}, s[i].ctl);
         end
         push_fwd(s[i].fa, s[i].fb, $sformatf("wrap step %0d", i));
      end
      tick();
      exp_stalls = 0;
      n_checks++;
      if (bus.stall_count !== 32'd0) begin
         n_fails++;
         $display("FAIL wrap stall_count: got %h want 00000000", bus.stall_count);
      end
   endtask

   task automatic test_reset_mid_flush();
      step_t s[5];
      s = '{idle_s(), idle_s(),
            st(1, 2, 0, 1, 0, 1, 8, 1, 0, 'b0001, 0, 0),
            st(1, 8, 8, 1, 1, 1, 9, 0, 0, 'b1100, 0, 0),
            st(1, 8, 8, 1, 1, 1, 9, 0, 1, 'b0010, 2, 2)};
      // Last row issues nothing, so its selects load 0; fix the expectation accordingly.
      s[4].fa = 2'd0;
      s[4].fb = 2'd0;
      foreach (s[i]) begin
         drive(s[i]);
         #2;
         n_checks++;
         if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue} !== s[i].ctl) begin
            n_fails++;
            $display("FAIL rst_flush step %0d ctl: got %b want %b", i,
                     {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue}, s[i].ctl);
         end
         push_fwd(s[i].fa, s[i].fb, $sformatf("rst_flush step %0d", i));
         tick();
      end
      drive(idle_s());
      #2;
      n_checks++;
      if (bus.flush_id !== 1'b1) begin
         n_fails++;
         $display("FAIL rst_flush in FLUSH flush_id: got %b want 1", bus.flush_id);
      end
      #1;
      rst_n = 1'b0;  // between clock edges: must act asynchronously
      #1;
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue, bus.fwd_a_sel,
           bus.fwd_b_sel} !== 8'd0) begin
         n_fails++;
         $display("FAIL rst_flush async outputs: got %b want 00000000",
                  {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue, bus.fwd_a_sel,
                   bus.fwd_b_sel});
      end
      n_checks++;
      if ({bus.stall_count, bus.flush_count, bus1.flush_count} !== 96'd0) begin
         n_fails++;
         $display("FAIL rst_flush async counters: got %h %h %h want 0", bus.stall_count,
                  bus.flush_count, bus1.flush_count);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      drive(st(1, 1, 2, 1, 1, 1, 5, 0, 0, 'b0001, 0, 0));
      #2;
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.issue} !== 4'b0001) begin
         n_fails++;
         $display("FAIL rst_flush release ctl: got %b want 0001",
                  {bus.stall_if, bus.stall_id, bus.flush_id, bus.issue});
      end
      push_fwd(2'd0, 2'd0, "rst_flush release");
      tick();
      drive(idle_s());
   endtask

   initial begin
      test_reset();
      test_alu_back_to_back();
      test_load_use();
      test_x0_priority();
      test_redirect();
      test_redirect_vs_load_use();
      test_counter_wrap();
      test_reset_mid_flush();
      tick();
      tick();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fails++;
         $display("FAIL scoreboard drain: got %0d pending want 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core (IF, ID, EX, MEM, WB). It sits beside the exec stage. It tracks the destination registers of the instructions in EX and MEM, and from that it produces:
- operand-forwarding selects for the exec stage,
- load-use stalls for fetch/decode,
- a multi-cycle squash sequence whenever exec asserts `pc_src`.

It also keeps free-running stall and flush event counters.

## Interface
- `FLUSH_CYCLES`, default 2: total cycles decode is squashed per redirect, counting the `pc_src` cycle; legal range 1..15.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `dec_valid` in 1: ID holds a real instruction.
- `dec_rs1_addr`, `dec_rs2_addr` in 5: source registers of the ID instruction.
- `dec_uses_rs1`, `dec_uses_rs2` in 1: ID instruction reads rs1 / rs2.
- `dec_rd_write_enable` in 1: ID instruction writes rd.
- `dec_rd_addr` in 5: ID instruction destination.
- `dec_is_load` in 1: ID instruction is a load (`res_src` = memory).
- `pc_src` in 1: exec redirect (taken branch/jump) for the instruction currently in EX.
- `stall_if` out 1: hold PC and the IF/ID register.
- `stall_id` out 1: hold the ID stage.
- `flush_id` out 1: squash the ID instruction; EX receives a bubble.
- `issue` out 1: ID instruction advances into EX this cycle.
- `fwd_a_sel`, `fwd_b_sel` out 2: registered; 0 = register file, 1 = EX/MEM `exec_out`, 2 = MEM/WB result; 3 is never driven.
- `stall_count`, `flush_count` out 32: event counters.

## Operation
- **Scoreboard.** Two registered entries, EX and MEM, each holding {v, wr, rd[4:0], ld}.
  - Each edge: MEM ← EX.
  - EX ← {1, `dec_rd_write_enable` && `dec_rd_addr`≠0, `dec_rd_addr`, `dec_is_load`} if `issue`, else all zero (bubble).
- **Combinational decode of hazards.**
  - match_X(rs) = X.v && X.wr && X.rd == rs.
  - hz_load = state==RUN && `dec_valid` && EX.ld && (`dec_uses_rs1` && match_EX(rs1) || `dec_uses_rs2` && match_EX(rs2)).
  - `stall_if` = `stall_id` = hz_load && !`pc_src`.
  - `flush_id` = `pc_src` || state==FLUSH.
  - `issue` = `dec_valid` && !hz_load && !`flush_id`.
- **Forwarding.** Computed per operand; loaded at the edge when `issue`=1, otherwise loaded with 0:
  - 1 if the operand is used and match_EX and !EX.ld;
  - else 2 if the operand is used and match_MEM;
  - else 0.
  - EX has priority over MEM (youngest producer wins).
  - x0 never forwards, because `wr` is cleared when rd = 0.
  - The register file is write-first, so WB-stage producers need no bypass.
- **FSM.** Two states, RUN and FLUSH, plus a 4-bit counter `cnt`.
  - RUN: if `pc_src` and FLUSH_CYCLES>1, go to FLUSH with `cnt` = FLUSH_CYCLES−1; otherwise stay in RUN.
  - FLUSH: if `cnt`==1, go to RUN; otherwise `cnt`−1.
  - `pc_src` is ignored in FLUSH, since EX holds only bubbles.
- **Priority.** Redirect beats load-use: with `pc_src` and hz_load in the same cycle, there is no stall, ID is flushed, and `stall_count` does not increment.
- **Counters.**
  - `stall_count` +1 every cycle `stall_id`=1.
  - `flush_count` +1 every cycle `pc_src`=1 in RUN.
  - Both wrap modulo 2^32.

## Timing
- **Reset.** While `rst_n`=0: state = RUN, `cnt`=0, both scoreboard entries zero, `fwd_*_sel`=0, counters 0. With `dec_valid`=0 the outputs are then `stall_if`=`stall_id`=`flush_id`=`issue`=0.
  - Assertion mid-FLUSH or mid-stall abandons the sequence immediately.
- **Latency.**
  - `stall_*`, `flush_id` and `issue` are combinational, same cycle as their inputs.
  - `fwd_*_sel` become valid the cycle after `issue`, aligned with the instruction in EX.
- **Load-use.** Exactly one stall cycle. Next cycle EX is a bubble, the load is in MEM, hz_load drops, and the consumer issues with sel=2.
- **Redirect.** `flush_id`=1 for exactly FLUSH_CYCLES consecutive cycles starting at the `pc_src` cycle, and `issue`=0 throughout.
- **Stall held.** A stall held by a constant `dec_valid` instruction releases one cycle after it starts.

## Test plan
- **Reset:** `rst_n`=0 mid-FLUSH → all outputs/counters 0 asynchronously. After release with `dec_valid`=1 and no hazards → `issue`=1.
- **ALU back-to-back:** issue `add x5`, then `sub x6,x5,x7` → `issue`=1 both cycles, `fwd_a_sel`=1, `fwd_b_sel`=0 in the sub's EX cycle. Same consumer one slot later (bubble between) → `fwd_a_sel`=2.
- **Load-use:** `lw x8`, then `add x9,x8,x8` → one cycle `stall_if`=`stall_id`=1, `issue`=0, `stall_count`=1. Next cycle `issue`=1, then `fwd_a_sel`=`fwd_b_sel`=2.
- **x0 and priority:** producer writes rd=0, consumer reads x0 → sel=0, no stall. Producers to x3 in both EX and MEM → sel=1.
- **Redirect, FLUSH_CYCLES=2:**
  - `pc_src` pulse → `flush_id`=1 for 2 cycles, `flush_count`=1, `issue`=0.
  - With FLUSH_CYCLES=1 → a single `flush_id` cycle.
- **Redirect vs load-use in same cycle:** → `stall_id`=0, `flush_id`=1, `stall_count` unchanged. Also preload `stall_count`=32'hFFFFFFFF via stalls/force, stall once → 0.
